// File: rtl/mpf_pll_rst_pkg.sv
// Shared types and sizing helpers for the MPF PLL reset/lock sequencer.
package mpf_pll_rst_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      READY,
      FAILED
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mpf_sync_bit.sv
// Multi-flop single-bit synchroniser for an asynchronous level input.
module mpf_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE", false_path = "TRUE" *)
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mpf_pll_rst_ctrl.sv
// PLL reset/lock sequencer on refclk: reset pulse, lock wait with bounded retries,
// lock stability qualification, then downstream reset release.
module mpf_pll_rst_ctrl
   import mpf_pll_rst_pkg::*;
#(
   parameter int  RST_HOLD_CYCLES     = 16,
   parameter int  LOCK_TIMEOUT_CYCLES = 100000,
   parameter int  LOCK_STABLE_CYCLES  = 1024,
   parameter int  MAX_RETRIES         = 3,
   parameter int  SYNC_STAGES         = 2,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic          refclk,
   input  logic          rst_n,
   input  logic          pll_locked,
   input  logic          soft_reset_req,
   output logic          pll_rst,
   output logic          user_rst_n,
   output logic          pll_ready,
   output logic          pll_fail,
   output logic          lock_lost,
   output logic [RW-1:0] retry_cnt
);

   localparam int CMAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          lost_d;
   logic          pll_rst_q, user_rst_n_q, ready_q, fail_q, lost_q;
   logic          locked_s;

   mpf_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk_i   (refclk),
      .rst_n_i (rst_n),
      .d_i     (pll_locked),
      .q_o     (locked_s)
   );

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lost_d  = 1'b0;
      if (soft_reset_req) begin
         state_d = RESET_PLL;
         retry_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               // a lock seen on the timeout edge takes precedence over the retry
               if (locked_s) state_d = STABILIZE;
               else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  if (retry_q == RW'(MAX_RETRIES)) state_d = FAILED;
                  else begin
                     state_d = RESET_PLL;
                     retry_d = retry_q + 1'b1;
                  end
               end
            end
            STABILIZE: begin
               if (!locked_s) state_d = WAIT_LOCK;
               else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = READY;
            end
            READY: if (!locked_s) begin
               state_d = RESET_PLL;
               retry_d = '0;
               lost_d  = 1'b1;
            end
            FAILED:  state_d = FAILED;
            default: state_d = RESET_PLL;
         endcase
      end

      if (soft_reset_req || (state_d != state_q)) cnt_d = '0;
      else if (state_q == READY || state_q == FAILED) cnt_d = cnt_q;
      else cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RESET_PLL;
         cnt_q        <= '0;
         retry_q      <= '0;
         pll_rst_q    <= 1'b1;
         user_rst_n_q <= 1'b0;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         pll_rst_q    <= (state_d == RESET_PLL) || (state_d == FAILED);
         user_rst_n_q <= (state_d == READY);
         ready_q      <= (state_d == READY);
         fail_q       <= (state_d == FAILED);
         lost_q       <= lost_d;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign user_rst_n = user_rst_n_q;
   assign pll_ready  = ready_q;
   assign pll_fail   = fail_q;
   assign lock_lost  = lost_q;
   assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_mpf_pll_rst_ctrl.sv
// Scenario bench: expected output changes are queued with their refclk edge number
// when stimulus is issued; a monitor pops and compares each observed output change.
module tb_mpf_pll_rst_ctrl;

   localparam int HOLD   = 16;
   localparam int TMO    = 200;
   localparam int STABLE = 1024;
   localparam int SYNC   = 2;
   localparam int READY_LAT = SYNC + STABLE + 1;

   logic       refclk, rst_n, pll_locked, soft_reset_req;
   logic       pll_rst, user_rst_n, pll_ready, pll_fail, lock_lost;
   logic [1:0] retry_cnt;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      logic [6:0] v;
   } ev_t;
   ev_t exp_q[$];

   mpf_pll_rst_ctrl #(
      .RST_HOLD_CYCLES     (HOLD),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .LOCK_STABLE_CYCLES  (STABLE),
      .MAX_RETRIES         (3),
      .SYNC_STAGES         (SYNC)
   ) dut (
      .refclk         (refclk),
      .rst_n          (rst_n),
      .pll_locked     (pll_locked),
      .soft_reset_req (soft_reset_req),
      .pll_rst        (pll_rst),
      .user_rst_n     (user_rst_n),
      .pll_ready      (pll_ready),
      .pll_fail       (pll_fail),
      .lock_lost      (lock_lost),
      .retry_cnt      (retry_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   // {pll_rst, user_rst_n, pll_ready, pll_fail, lock_lost, retry_cnt}
   function automatic logic [6:0] V(input logic r, input logic u, input logic rd,
                                    input logic f, input logic ll, input logic [1:0] rc);
      return {r, u, rd, f, ll, rc};
   endfunction

   function automatic logic [6:0] outv();
      return {pll_rst, user_rst_n, pll_ready, pll_fail, lock_lost, retry_cnt};
   endfunction

   function automatic logic [6:0] v_rst(input int rc);
      return V(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(rc));
   endfunction

   function automatic logic [6:0] v_wait(input int rc);
      return V(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(rc));
   endfunction

   task automatic push(input int c, input logic [6:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   // Every observed output change must be the next expected event, on its edge.
   task automatic monitor();
      logic [6:0] prev, cur;
      ev_t        e;
      prev = v_rst(0);
      forever begin
         @(negedge refclk or negedge rst_n);
         #1;
         cur = outv();
         if (cur !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v !== cur) begin
                  n_bad++;
                  $display("FAIL output_event got cyc=%0d out=%b, expected cyc=%0d out=%b",
                           cyc, cur, e.cyc, e.v);
               end
            end
            prev = cur;
         end
      end
   endtask

   task automatic lock_up();
      pll_locked = 1'b1;
      push(cyc + READY_LAT, V(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
   endtask

   task automatic soft_pulse();
      int s;
      s = cyc;
      soft_reset_req = 1'b1;
      push(s + 1, v_rst(0));
      push(s + 1 + HOLD, v_wait(0));
      tick(1);
      soft_reset_req = 1'b0;
   endtask

   initial begin
      int t, d;
      rst_n = 1'b1;
      pll_locked = 1'b0;
      soft_reset_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (outv() !== v_rst(0)) begin
         n_bad++;
         $display("FAIL reset_state got=%b expected=%b", outv(), v_rst(0));
      end
      fork
         monitor();
      join_none
      tick(3);

      // normal lock
      rst_n = 1'b1;
      push(cyc + HOLD, v_wait(0));
      tick(HOLD + rnd(20, 150));
      lock_up();
      tick(READY_LAT + rnd(5, 50));

      // lock loss in READY, then a glitch while stabilising on the relock
      pll_locked = 1'b0;
      d = cyc;
      push(d + SYNC + 1, V(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      push(d + SYNC + 2, v_rst(0));
      push(d + SYNC + 1 + HOLD, v_wait(0));
      tick(SYNC + 1 + HOLD + rnd(5, 80));
      pll_locked = 1'b1;
      tick(SYNC + 1 + rnd(10, 500));
      pll_locked = 1'b0;
      tick(rnd(3, 60));
      lock_up();
      tick(READY_LAT + rnd(5, 50));

      // no lock: every attempt times out until FAILED
      pll_locked = 1'b0;
      soft_reset_req = 1'b1;
      t = cyc + 1;
      push(t, v_rst(0));
      tick(1);
      soft_reset_req = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         push(t + HOLD, v_wait(k));
         t += HOLD + TMO;
         if (k < 3) push(t, v_rst(k + 1));
         else       push(t, V(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3));
      end
      tick(t - cyc + rnd(5, 40));

      // recover from FAILED; lock lands exactly on the timeout edge
      t = cyc + 1 + HOLD;
      soft_pulse();
      tick(t + TMO - (SYNC + 1) - cyc);
      lock_up();
      tick(READY_LAT + rnd(5, 50));

      // async reset in the middle of STABILIZE
      soft_pulse();
      tick(HOLD + rnd(5, 100));
      pll_locked = 1'b1;
      tick(SYNC + 1 + rnd(10, 500));
      #2;
      push(cyc, v_rst(0));
      rst_n = 1'b0;
      pll_locked = 1'b0;
      tick(2);
      rst_n = 1'b1;
      push(cyc + HOLD, v_wait(0));
      tick(HOLD + rnd(20, 150));
      lock_up();
      tick(READY_LAT + 10);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events got=%0d pending, expected=0 (next at cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
